// File: rtl/issue_rr_arbiter.sv
// Issue-stage round-robin wavefront picker with a registered grant. The previously issued
// wavefront is masked for one cycle because its valid_entry bit clears one cycle late.
module issue_rr_arbiter #(
  parameter int unsigned WF_PER_CU    = 40,
  parameter int unsigned WF_ID_LENGTH = 6,
  parameter int unsigned STALL_CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    valid_entry_in,
  input  logic [WF_PER_CU-1:0]    wf_ready_in,
  input  logic                    fu_ready,
  output logic                    issued_valid,
  output logic [WF_ID_LENGTH-1:0] issued_wfid,
  output logic [WF_ID_LENGTH-1:0] rr_ptr_out,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  localparam logic [WF_ID_LENGTH-1:0] LastId = WF_ID_LENGTH'(WF_PER_CU - 1);

  logic                    issued_valid_q;
  logic [WF_ID_LENGTH-1:0] issued_wfid_q;
  logic [WF_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [WF_PER_CU-1:0]    last_mask;
  logic [WF_PER_CU-1:0]    elig;
  logic                    any_elig;
  logic                    grant;
  logic                    hi_found, lo_found;
  logic [WF_ID_LENGTH-1:0] hi_sel, lo_sel, sel;

  always_comb begin
    last_mask = '0;
    for (int unsigned i = 0; i < WF_PER_CU; i++) begin
      last_mask[i] = issued_valid_q && (issued_wfid_q == WF_ID_LENGTH'(i));
    end
  end

  assign elig     = valid_entry_in & wf_ready_in & ~last_mask;
  assign any_elig = |elig;
  assign grant    = fu_ready & any_elig;

  // Rotating search as two priority encoders: lowest eligible id at or above the pointer,
  // falling back to the lowest eligible id overall. Wrap happens at WF_PER_CU-1, not 2^n.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int unsigned i = 0; i < WF_PER_CU; i++) begin
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_sel   = WF_ID_LENGTH'(i);
      end
      if (elig[i] && !hi_found && (WF_ID_LENGTH'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_sel   = WF_ID_LENGTH'(i);
      end
    end
  end

  assign sel = hi_found ? hi_sel : lo_sel;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (sel == LastId) ? '0 : sel + 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fu_ready && any_elig && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_valid_q <= 1'b0;
      issued_wfid_q  <= '0;
      rr_ptr_q       <= '0;
      stall_cnt_q    <= '0;
    end else begin
      issued_valid_q <= grant;
      if (grant) begin
        issued_wfid_q <= sel;
      end
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issued_valid = issued_valid_q;
  assign issued_wfid  = issued_wfid_q;
  assign rr_ptr_out   = rr_ptr_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_issue_rr_arbiter.sv
// Directed bench for issue_rr_arbiter: expected issues go into a scoreboard queue, and a
// negedge monitor pops and compares them whenever issued_valid is seen.
module tb_issue_rr_arbiter;

  localparam int unsigned N  = 40;
  localparam int unsigned IW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  valid_entry_in = '0;
  logic [N-1:0]  wf_ready_in = '0;
  logic          fu_ready = 1'b0;

  logic          issued_valid;
  logic [IW-1:0] issued_wfid;
  logic [IW-1:0] rr_ptr_out;
  logic [31:0]   stall_count;

  logic          s_issued_valid;
  logic [IW-1:0] s_issued_wfid;
  logic [IW-1:0] s_rr_ptr_out;
  logic [3:0]    s_stall_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  issue_rr_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .valid_entry_in (valid_entry_in),
    .wf_ready_in    (wf_ready_in),
    .fu_ready       (fu_ready),
    .issued_valid   (issued_valid),
    .issued_wfid    (issued_wfid),
    .rr_ptr_out     (rr_ptr_out),
    .stall_count    (stall_count)
  );

  issue_rr_arbiter #(.STALL_CNT_W(4)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .valid_entry_in (valid_entry_in),
    .wf_ready_in    (wf_ready_in),
    .fu_ready       (fu_ready),
    .issued_valid   (s_issued_valid),
    .issued_wfid    (s_issued_wfid),
    .rr_ptr_out     (s_rr_ptr_out),
    .stall_count    (s_stall_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && issued_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got wfid %0d, expected no issue at %0t", issued_wfid,
                 $time);
      end else begin
        check("issued_wfid", longint'(issued_wfid), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_entry_in = '0;
    wf_ready_in = '0;
    fu_ready = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic set_bits(input int a, input int b, input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    valid_entry_in = v;
    wf_ready_in = v;
  endtask

  initial begin
    // Reset held with everything asserted
    rst = 1'b0;
    valid_entry_in = '1;
    wf_ready_in = '1;
    fu_ready = 1'b1;
    step(3);
    check("reset_issued_valid", longint'(issued_valid), 0);
    check("reset_issued_wfid", longint'(issued_wfid), 0);
    check("reset_stall_count", longint'(stall_count), 0);
    check("reset_rr_ptr", longint'(rr_ptr_out), 0);

    // Round robin with wrap: 3,5,39,3,5,39
    do_reset();
    step(1);
    set_bits(3, 5, 39);
    fu_ready = 1'b1;
    exp_q.push_back(3);  exp_q.push_back(5);  exp_q.push_back(39);
    exp_q.push_back(3);  exp_q.push_back(5);  exp_q.push_back(39);
    step(1);
    check("rr_ptr_after_3", longint'(rr_ptr_out), 4);
    step(2);
    check("rr_ptr_after_39", longint'(rr_ptr_out), 0);
    step(3);
    set_bits(-1, -1, -1);
    step(2);
    check("rr_queue_drained", exp_q.size(), 0);

    // Double-issue mask: valid bit 7 clears one cycle after issued_valid
    do_reset();
    step(1);
    set_bits(7, -1, -1);
    fu_ready = 1'b1;
    exp_q.push_back(7);
    step(1);
    check("mask_first_issue_valid", longint'(issued_valid), 1);
    step(1);
    check("mask_no_reissue", longint'(issued_valid), 0);
    set_bits(-1, -1, -1);
    step(2);
    check("mask_still_idle", longint'(issued_valid), 0);

    // Backpressure on {2,9}
    do_reset();
    step(1);
    set_bits(2, 9, -1);
    fu_ready = 1'b0;
    step(4);
    check("bp_stall_count", longint'(stall_count), 4);
    check("bp_rr_ptr_held", longint'(rr_ptr_out), 0);
    check("bp_no_issue", longint'(issued_valid), 0);
    fu_ready = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(9);
    step(1);
    check("bp_rr_ptr_after_2", longint'(rr_ptr_out), 3);
    step(1);
    check("bp_rr_ptr_after_9", longint'(rr_ptr_out), 10);
    set_bits(-1, -1, -1);
    step(2);
    check("bp_stall_count_final", longint'(stall_count), 4);

    // Ready gating on wf 12
    do_reset();
    step(1);
    fu_ready = 1'b1;
    valid_entry_in = '0;
    valid_entry_in[12] = 1'b1;
    wf_ready_in = '0;
    step(3);
    check("gate_no_issue", longint'(issued_valid), 0);
    wf_ready_in[12] = 1'b1;
    exp_q.push_back(12);
    step(1);
    check("gate_issue_after_ready", longint'(issued_valid), 1);
    valid_entry_in = '0;
    wf_ready_in = '0;
    step(2);

    // Saturation on the 4-bit counter build, then async reset mid-stream
    do_reset();
    step(1);
    set_bits(20, -1, -1);
    fu_ready = 1'b0;
    step(20);
    check("sat_stall_count_4bit", longint'(s_stall_count), 15);
    check("sat_stall_count_32bit", longint'(stall_count), 20);
    fu_ready = 1'b1;
    step(1);
    check("pre_reset_issued_valid", longint'(issued_valid), 1);
    check("pre_reset_issued_wfid", longint'(issued_wfid), 20);
    check("pre_reset_rr_ptr", longint'(rr_ptr_out), 21);
    #1;
    rst = 1'b0;
    #1;
    check("async_issued_valid", longint'(issued_valid), 0);
    check("async_issued_wfid", longint'(issued_wfid), 0);
    check("async_rr_ptr", longint'(rr_ptr_out), 0);
    check("async_stall_count", longint'(stall_count), 0);
    check("async_stall_count_4bit", longint'(s_stall_count), 0);
    step(1);
    set_bits(1, 30, -1);
    rst = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(30);
    step(2);
    set_bits(-1, -1, -1);
    step(3);
    check("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
